// File: rtl/friscv_icache_linefill.sv
// Instruction cache line refill: turns one fetch miss into an AXI4 INCR burst
// and writes the assembled line back into the cache in a single cycle.
module friscv_icache_linefill #(
    parameter int AXI_ADDR_W    = 32,
    parameter int AXI_ID_W      = 8,
    parameter int AXI_DATA_W    = 32,
    parameter int CACHE_BLOCK_W = 128
) (
    input  logic                     aclk,
    input  logic                     srst,
    input  logic                     flush_req,
    output logic                     flush_ack,
    input  logic                     memctrl_arvalid,
    output logic                     memctrl_arready,
    input  logic [AXI_ADDR_W-1:0]    memctrl_araddr,
    input  logic [2:0]               memctrl_arprot,
    input  logic [AXI_ID_W-1:0]      memctrl_arid,
    output logic                     mem_arvalid,
    input  logic                     mem_arready,
    output logic [AXI_ADDR_W-1:0]    mem_araddr,
    output logic [7:0]               mem_arlen,
    output logic [2:0]               mem_arsize,
    output logic [1:0]               mem_arburst,
    output logic [2:0]               mem_arprot,
    output logic [AXI_ID_W-1:0]      mem_arid,
    input  logic                     mem_rvalid,
    output logic                     mem_rready,
    input  logic [AXI_ID_W-1:0]      mem_rid,
    input  logic [1:0]               mem_rresp,
    input  logic [AXI_DATA_W-1:0]    mem_rdata,
    input  logic                     mem_rlast,
    output logic                     cache_wen,
    output logic [AXI_ADDR_W-1:0]    cache_waddr,
    output logic [CACHE_BLOCK_W-1:0] cache_wdata,
    output logic                     cache_writing,
    output logic                     fill_err
);

    localparam int BEATS = CACHE_BLOCK_W / AXI_DATA_W;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam int OFFS  = $clog2(CACHE_BLOCK_W / 8);
    localparam int SIZE  = $clog2(AXI_DATA_W / 8);

    localparam logic [AXI_ADDR_W-1:0] OFFS_MASK =
        AXI_ADDR_W'((64'd1 << OFFS) - 64'd1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        WRITE
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [AXI_ADDR_W-1:0]    addr;
    logic [AXI_ID_W-1:0]      id;
    logic [2:0]               prot;
    logic [CACHE_BLOCK_W-1:0] line;
    logic                     err;
    logic                     ack;

    logic miss_hs;
    logic ar_hs;
    logic r_hs;
    logic last_beat;
    logic beat_err;
    logic unused_rid;

    // R ID is not checked: only one burst is ever outstanding
    assign unused_rid = ^mem_rid;

    assign memctrl_arready = (state == IDLE) && !flush_req;
    assign miss_hs   = memctrl_arvalid && memctrl_arready;
    assign ar_hs     = (state == REQ) && mem_arready;
    assign r_hs      = (state == FILL) && mem_rvalid;
    assign last_beat = (cnt == CNT_W'(BEATS - 1));

    // rlast must line up exactly with the final beat of the line
    assign beat_err  = (mem_rresp != 2'b00) || (mem_rlast != last_beat);

    assign mem_arvalid   = (state == REQ);
    assign mem_araddr    = addr;
    assign mem_arlen     = 8'(BEATS - 1);
    assign mem_arsize    = 3'(SIZE);
    assign mem_arburst   = 2'b01;
    assign mem_arprot    = prot;
    assign mem_arid      = id;
    assign mem_rready    = (state == FILL);

    assign cache_wen     = (state == WRITE);
    assign cache_writing = (state == WRITE);
    assign cache_waddr   = addr;
    assign cache_wdata   = line;

    assign fill_err  = r_hs && last_beat && (err || beat_err);
    assign flush_ack = ack;

    always_ff @(posedge aclk) begin
        if (srst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (miss_hs) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_arready) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (r_hs && last_beat) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            cnt  <= '0;
            addr <= '0;
            id   <= '0;
            prot <= '0;
            line <= '0;
            err  <= 1'b0;
            ack  <= 1'b0;
        end else begin
            // ack holds while the request stays up, once seen idle
            ack <= flush_req && (ack || (state == IDLE));
            if (miss_hs) begin
                addr <= memctrl_araddr & ~OFFS_MASK;
                id   <= memctrl_arid;
                prot <= memctrl_arprot;
            end
            if (ar_hs) begin
                cnt <= '0;
                err <= 1'b0;
            end
            if (r_hs) begin
                for (int k = 0; k < BEATS; k++) begin
                    if (cnt == CNT_W'(k)) begin
                        line[k*AXI_DATA_W +: AXI_DATA_W] <= mem_rdata;
                    end
                end
                cnt <= cnt + CNT_W'(1);
                err <= err || beat_err;
            end
        end
    end

endmodule

// File: tb/tb_friscv_icache_linefill.sv
// Directed bench for friscv_icache_linefill (32-bit beats, 128-bit line).
module tb_friscv_icache_linefill;

    logic         aclk = 1'b0;
    logic         srst;
    logic         flush_req;
    logic         flush_ack;
    logic         memctrl_arvalid;
    logic         memctrl_arready;
    logic [31:0]  memctrl_araddr;
    logic [2:0]   memctrl_arprot;
    logic [7:0]   memctrl_arid;
    logic         mem_arvalid;
    logic         mem_arready;
    logic [31:0]  mem_araddr;
    logic [7:0]   mem_arlen;
    logic [2:0]   mem_arsize;
    logic [1:0]   mem_arburst;
    logic [2:0]   mem_arprot;
    logic [7:0]   mem_arid;
    logic         mem_rvalid;
    logic         mem_rready;
    logic [7:0]   mem_rid;
    logic [1:0]   mem_rresp;
    logic [31:0]  mem_rdata;
    logic         mem_rlast;
    logic         cache_wen;
    logic [31:0]  cache_waddr;
    logic [127:0] cache_wdata;
    logic         cache_writing;
    logic         fill_err;

    int nvec = 0;
    int nmis = 0;
    int wen_cnt = 0;

    friscv_icache_linefill dut (
        .aclk            (aclk),
        .srst            (srst),
        .flush_req       (flush_req),
        .flush_ack       (flush_ack),
        .memctrl_arvalid (memctrl_arvalid),
        .memctrl_arready (memctrl_arready),
        .memctrl_araddr  (memctrl_araddr),
        .memctrl_arprot  (memctrl_arprot),
        .memctrl_arid    (memctrl_arid),
        .mem_arvalid     (mem_arvalid),
        .mem_arready     (mem_arready),
        .mem_araddr      (mem_araddr),
        .mem_arlen       (mem_arlen),
        .mem_arsize      (mem_arsize),
        .mem_arburst     (mem_arburst),
        .mem_arprot      (mem_arprot),
        .mem_arid        (mem_arid),
        .mem_rvalid      (mem_rvalid),
        .mem_rready      (mem_rready),
        .mem_rid         (mem_rid),
        .mem_rresp       (mem_rresp),
        .mem_rdata       (mem_rdata),
        .mem_rlast       (mem_rlast),
        .cache_wen       (cache_wen),
        .cache_waddr     (cache_waddr),
        .cache_wdata     (cache_wdata),
        .cache_writing   (cache_writing),
        .fill_err        (fill_err)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (cache_wen) wen_cnt <= wen_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] act,
                       input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge aclk);
    endtask

    task automatic chk_req(input logic [31:0] a, input logic [7:0] id,
                           input logic [2:0] pr);
        chk("arvalid", 128'(mem_arvalid), 128'(1'b1));
        chk("araddr", 128'(mem_araddr), 128'(a));
        chk("arlen", 128'(mem_arlen), 128'(8'd3));
        chk("arsize", 128'(mem_arsize), 128'(3'b010));
        chk("arburst", 128'(mem_arburst), 128'(2'b01));
        chk("arid", 128'(mem_arid), 128'(id));
        chk("arprot", 128'(mem_arprot), 128'(pr));
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] al,
                         input logic [7:0] id, input logic [2:0] pr);
        memctrl_arvalid = 1'b1;
        memctrl_araddr  = a;
        memctrl_arid    = id;
        memctrl_arprot  = pr;
        #1 chk("arready", 128'(memctrl_arready), 128'(1'b1));
        tick;
        memctrl_arvalid = 1'b0;
        #1 chk_req(al, id, pr);
    endtask

    task automatic serve(input logic [31:0] al, input logic [7:0] id,
                         input logic [2:0] pr, input int ar_wait,
                         input int r_gap, input int err_beat,
                         input int last_at, input logic exp_err,
                         input logic [31:0] base, input int flush_at);
        logic [127:0] line;
        int w0;
        line = '0;
        w0 = wen_cnt;
        mem_arready = (ar_wait == 0);
        for (int i = 0; i < ar_wait; i++) begin
            tick;
            if (i == ar_wait - 1) mem_arready = 1'b1;
            #1 chk_req(al, id, pr);
        end
        tick;
        mem_arready = 1'b0;
        #1 chk("ar_clear", 128'(mem_arvalid), 128'(1'b0));
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < r_gap; g++) begin
                mem_rvalid = 1'b0;
                mem_rdata  = 32'hDEAD_BEEF;
                #1 chk("gap_wen", 128'(cache_wen), 128'(1'b0));
                tick;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = base + 32'(k);
            mem_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
            mem_rlast  = (k == last_at);
            if (k == flush_at) begin
                flush_req       = 1'b1;
                memctrl_arvalid = 1'b1;
                memctrl_araddr  = 32'h2000_0044;
                memctrl_arid    = 8'h3C;
                memctrl_arprot  = 3'b001;
            end
            line[k*32 +: 32] = base + 32'(k);
            #1;
            chk("rready", 128'(mem_rready), 128'(1'b1));
            chk("beat_wen", 128'(cache_wen), 128'(1'b0));
            chk("busy_arrdy", 128'(memctrl_arready), 128'(1'b0));
            chk("fill_err", 128'(fill_err),
                128'((k == 3) ? exp_err : 1'b0));
            tick;
        end
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        mem_rresp  = 2'b00;
        #1;
        chk("wen", 128'(cache_wen), 128'(1'b1));
        chk("writing", 128'(cache_writing), 128'(1'b1));
        chk("waddr", 128'(cache_waddr), 128'(al));
        chk("wdata", cache_wdata, line);
        chk("err_wr", 128'(fill_err), 128'(1'b0));
        tick;
        #1;
        chk("wen_off", 128'(cache_wen), 128'(1'b0));
        chk("writing_off", 128'(cache_writing), 128'(1'b0));
        chk("wen_once", 128'(wen_cnt - w0), 128'(1));
        chk("idle_arrdy", 128'(memctrl_arready), 128'(!flush_req));
        chk("ack_late", 128'(flush_ack), 128'(1'b0));
    endtask

    initial begin
        int w0;
        srst = 1'b1;
        flush_req = 1'b0;
        memctrl_arvalid = 1'b0;
        memctrl_araddr = 32'h0;
        memctrl_arprot = 3'b0;
        memctrl_arid = 8'h0;
        mem_arready = 1'b0;
        mem_rvalid = 1'b1;
        mem_rid = 8'h0;
        mem_rresp = 2'b00;
        mem_rdata = 32'h0;
        mem_rlast = 1'b0;
        tick;
        tick;
        #1;
        chk("rst_arvalid", 128'(mem_arvalid), 128'(1'b0));
        chk("rst_rready", 128'(mem_rready), 128'(1'b0));
        chk("rst_wen", 128'(cache_wen), 128'(1'b0));
        chk("rst_ack", 128'(flush_ack), 128'(1'b0));
        chk("rst_wdata", cache_wdata, 128'(0));
        chk("rst_araddr", 128'(mem_araddr), 128'(0));
        srst = 1'b0;
        tick;
        #1 chk("idle_rready", 128'(mem_rready), 128'(1'b0));
        mem_rvalid = 1'b0;

        issue(32'h0000_1234, 32'h0000_1230, 8'h05, 3'b010);
        serve(32'h0000_1230, 8'h05, 3'b010, 0, 0, -1, 3, 1'b0,
              32'h0000_00A0, -1);

        issue(32'h0000_1234, 32'h0000_1230, 8'h05, 3'b010);
        serve(32'h0000_1230, 8'h05, 3'b010, 5, 2, -1, 3, 1'b0,
              32'h0000_00A0, -1);

        issue(32'h0000_8ABC, 32'h0000_8AB0, 8'h21, 3'b100);
        serve(32'h0000_8AB0, 8'h21, 3'b100, 0, 0, 2, 3, 1'b1,
              32'h1000_0000, -1);

        issue(32'h0000_5558, 32'h0000_5550, 8'h09, 3'b000);
        serve(32'h0000_5550, 8'h09, 3'b000, 0, 1, -1, 1, 1'b1,
              32'h0000_00B0, -1);

        issue(32'h0000_4440, 32'h0000_4440, 8'h07, 3'b011);
        serve(32'h0000_4440, 8'h07, 3'b011, 0, 0, -1, 3, 1'b0,
              32'h0000_00C0, 1);
        tick;
        #1;
        chk("ack_on", 128'(flush_ack), 128'(1'b1));
        chk("fl_arrdy", 128'(memctrl_arready), 128'(1'b0));
        tick;
        #1;
        chk("ack_hold", 128'(flush_ack), 128'(1'b1));
        chk("fl_noreq", 128'(mem_arvalid), 128'(1'b0));
        tick;
        flush_req = 1'b0;
        #1;
        chk("unfl_arrdy", 128'(memctrl_arready), 128'(1'b1));
        chk("ack_fall", 128'(flush_ack), 128'(1'b1));
        tick;
        memctrl_arvalid = 1'b0;
        #1;
        chk("ack_off", 128'(flush_ack), 128'(1'b0));
        chk_req(32'h2000_0040, 8'h3C, 3'b001);
        serve(32'h2000_0040, 8'h3C, 3'b001, 0, 0, -1, 3, 1'b0,
              32'h0000_00D0, -1);

        w0 = wen_cnt;
        issue(32'h0000_3008, 32'h0000_3000, 8'h11, 3'b110);
        mem_arready = 1'b1;
        tick;
        mem_arready = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h0000_00E0;
        tick;
        mem_rdata = 32'h0000_00E1;
        tick;
        mem_rvalid = 1'b0;
        srst = 1'b1;
        tick;
        srst = 1'b0;
        #1;
        chk("srst_arvalid", 128'(mem_arvalid), 128'(1'b0));
        chk("srst_rready", 128'(mem_rready), 128'(1'b0));
        chk("srst_araddr", 128'(mem_araddr), 128'(0));
        chk("srst_arid", 128'(mem_arid), 128'(0));
        chk("srst_waddr", 128'(cache_waddr), 128'(0));
        chk("srst_wdata", cache_wdata, 128'(0));
        chk("srst_nowen", 128'(wen_cnt - w0), 128'(0));
        issue(32'h0000_3008, 32'h0000_3000, 8'h11, 3'b110);
        serve(32'h0000_3000, 8'h11, 3'b110, 0, 0, -1, 3, 1'b0,
              32'h0000_00F0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
